pc_gen_unit: RTL and testbench
==============================

PC_GEN_UNIT -- requirements
Module: pc_gen_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have parameter INC_BYTES, default 4, sequential increment.
REQ-004 SHALL have parameter ALIGN_BYTES, default 4 (power of two, ≥2), required target alignment.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port stall_i, input, 1, hold current PC.
REQ-008 SHALL have port redirect_valid_i, input, 1, branch/jump redirect request.
REQ-009 SHALL have port redirect_pc_i, input, XLEN, redirect target.
REQ-010 SHALL have port trap_valid_i, input, 1, trap redirect request.
REQ-011 SHALL have port trap_vec_i, input, XLEN, trap target.
REQ-012 SHALL have port halt_req_i, input, 1, enter HALT.
REQ-013 SHALL have port resume_i, input, 1, leave HALT.
REQ-014 SHALL have port pc_o, output, XLEN, current fetch PC (registered).
REQ-015 SHALL have port pc_valid_o, output, 1, pc_o is a valid fetch address.
REQ-016 SHALL have port misaligned_o, output, 1, one-cycle flag: last applied target misaligned.

Function
REQ-017 SHALL implement FSM states BOOT, RUN, HALT.
REQ-018 BOOT: pc_o = RESET_VECTOR, pc_valid_o = 0; unconditional transition to RUN next cycle; inputs ignored.
REQ-019 RUN, stall_i = 0: next pc_o selected by priority trap_valid_i > redirect_valid_i > pending redirect > pc_o + INC_BYTES.
REQ-020 RUN, stall_i = 1: pc_o held; an incoming trap or redirect SHALL be captured in a one-entry pending buffer instead of applied.
REQ-021 Pending buffer overwrite: trap replaces any pending entry; redirect replaces a pending redirect but never a pending trap.
REQ-022 Pending entry SHALL be applied on the first cycle with stall_i = 0 and no new request, then cleared; a new request in that cycle wins and clears the buffer.
REQ-023 Applying any target SHALL take one cycle: request sampled at edge N, pc_o shows target after edge N.
REQ-024 Addition SHALL be modulo 2^XLEN; pc_o = 2^XLEN − INC_BYTES wraps to 0 without flag.
REQ-025 misaligned_o SHALL be 1 for exactly the cycle following application of a target with target mod ALIGN_BYTES ≠ 0; pc_o still takes the target unmodified.
REQ-026 RUN, halt_req_i = 1 (stall_i ignored): transition to HALT next cycle; pc_o held; pc_valid_o = 0 in HALT; a same-cycle request goes to the pending buffer.
REQ-027 HALT: requests still captured per REQ-021; resume_i = 1 returns to RUN with pc_o unchanged; pending entry applied on next non-stalled RUN cycle; halt_req_i and resume_i both high in HALT → stay in HALT.
REQ-028 pc_valid_o SHALL be 1 in RUN regardless of stall_i.

Reset
REQ-029 rst = 1 at an edge SHALL force state BOOT, pc_o = RESET_VECTOR, pc_valid_o = 0, misaligned_o = 0, pending buffer empty, from any state including mid-stall or HALT.
REQ-030 rst SHALL take priority over every other input.

Structure
REQ-031 FSM enum pc_state_e and default parameter constants SHALL live in shared package pc_pkg.
REQ-032 Pending buffer SHALL be sub-module pc_redirect_buf (valid, is_trap, target; overwrite per REQ-021).

Verification
REQ-033 Reset then 3 free cycles, RESET_VECTOR = 0 -> BOOT pc_o = 0x0 valid 0, then 0x0 valid 1, then 0x4, 0x8.
REQ-034 At pc_o = 0x8, redirect 0x100 -> pc_o = 0x100, then 0x104.
REQ-035 Stall with pc_o = 0x104, redirect 0x200 then trap 0x80 then redirect 0x300 during stall, release -> pc_o = 0x104 held, then 0x80, then 0x84.
REQ-036 Same-cycle trap 0x80 and redirect 0x40 -> pc_o = 0x80; redirect 0x102 -> pc_o = 0x102 and misaligned_o = 1 for one cycle.
REQ-037 Halt at pc_o = 0x40, redirect 0x500 during HALT, resume -> pc_o 0x40 valid 0 while halted, then 0x40 valid 1, then 0x500.
REQ-038 pc_o = 0xFFFF_FFFC free-running -> 0x0000_0000, no flag; rst asserted during stall with pending entry -> BOOT, buffer empty, pc_o = RESET_VECTOR.

Source files
------------

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared FSM state type and default parameters for the PC generator
package pc_pkg;

    typedef enum logic [1:0] {
        PC_BOOT = 2'd0,
        PC_RUN  = 2'd1,
        PC_HALT = 2'd2
    } pc_state_e;

    localparam int          DEF_XLEN         = 32;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam int          DEF_INC_BYTES    = 4;
    localparam int          DEF_ALIGN_BYTES  = 4;

endpackage

// File: rtl/pc_redirect_buf.sv
// rtl/pc_redirect_buf.sv - one-entry pending redirect/trap buffer
// A trap overwrites anything; a redirect never displaces a pending trap.
module pc_redirect_buf #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_capture,
    input  logic            i_clear,
    input  logic            i_trap_valid,
    input  logic [XLEN-1:0] i_trap_vec,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_valid,
    output logic            o_is_trap,
    output logic [XLEN-1:0] o_target
);

    logic            r_valid;
    logic            r_is_trap;
    logic [XLEN-1:0] r_target;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_is_trap <= 1'b0;
            r_target  <= '0;
        end else if (i_capture) begin
            if (i_trap_valid) begin
                r_valid   <= 1'b1;
                r_is_trap <= 1'b1;
                r_target  <= i_trap_vec;
            end else if (i_redirect_valid && !(r_valid && r_is_trap)) begin
                r_valid   <= 1'b1;
                r_is_trap <= 1'b0;
                r_target  <= i_redirect_pc;
            end
        end else if (i_clear) begin
            r_valid   <= 1'b0;
            r_is_trap <= 1'b0;
        end
    end

    assign o_valid   = r_valid;
    assign o_is_trap = r_is_trap;
    assign o_target  = r_target;

endmodule

// File: rtl/pc_gen_unit.sv
// rtl/pc_gen_unit.sv - fetch PC generator with BOOT/RUN/HALT FSM and deferred redirects
// Requests arriving while stalled or halted are parked in pc_redirect_buf.
module pc_gen_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
    parameter int              INC_BYTES    = DEF_INC_BYTES,
    parameter int              ALIGN_BYTES  = DEF_ALIGN_BYTES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            halt_req_i,
    input  logic            resume_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic            misaligned_o
);

    localparam logic [XLEN-1:0] INC_VAL    = XLEN'(INC_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ALIGN_BYTES - 1);

    pc_state_e       r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_pc_valid;
    logic            r_misaligned;

    logic            w_capture;
    logic            w_advance;
    logic            w_buf_valid;
    logic            w_buf_is_trap;
    logic [XLEN-1:0] w_buf_target;
    logic            w_apply;
    logic [XLEN-1:0] w_target;

    // Stalled or halting RUN cycles and every HALT cycle park requests instead of applying them.
    assign w_capture = ((r_state == PC_RUN) && (halt_req_i || stall_i)) || (r_state == PC_HALT);
    assign w_advance = (r_state == PC_RUN) && !halt_req_i && !stall_i;

    always_comb begin
        w_apply  = trap_valid_i || redirect_valid_i || w_buf_valid;
        w_target = w_buf_target;
        if (trap_valid_i) begin
            w_target = trap_vec_i;
        end else if (redirect_valid_i) begin
            w_target = redirect_pc_i;
        end
    end

    pc_redirect_buf #(
        .XLEN(XLEN)
    ) u_buf (
        .clk             (clk),
        .rst             (rst),
        .i_capture       (w_capture),
        .i_clear         (w_advance),
        .i_trap_valid    (trap_valid_i),
        .i_trap_vec      (trap_vec_i),
        .i_redirect_valid(redirect_valid_i),
        .i_redirect_pc   (redirect_pc_i),
        .o_valid         (w_buf_valid),
        .o_is_trap       (w_buf_is_trap),
        .o_target        (w_buf_target)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= PC_BOOT;
            r_pc         <= RESET_VECTOR;
            r_pc_valid   <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= 1'b0;
            case (r_state)
                PC_BOOT: begin
                    r_state    <= PC_RUN;
                    r_pc       <= RESET_VECTOR;
                    r_pc_valid <= 1'b1;
                end
                PC_RUN: begin
                    if (halt_req_i) begin
                        r_state    <= PC_HALT;
                        r_pc_valid <= 1'b0;
                    end else if (!stall_i) begin
                        if (w_apply) begin
                            r_pc         <= w_target;
                            r_misaligned <= |(w_target & ALIGN_MASK);
                        end else begin
                            r_pc <= r_pc + INC_VAL;
                        end
                    end
                end
                PC_HALT: begin
                    if (resume_i && !halt_req_i) begin
                        r_state    <= PC_RUN;
                        r_pc_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= PC_BOOT;
                    r_pc       <= RESET_VECTOR;
                    r_pc_valid <= 1'b0;
                end
            endcase
        end
    end

    assign pc_o         = r_pc;
    assign pc_valid_o   = r_pc_valid;
    assign misaligned_o = r_misaligned;

    logic w_unused;
    assign w_unused = w_buf_is_trap;

endmodule

// File: tb/tb_pc_gen_unit.sv
// tb/tb_pc_gen_unit.sv - directed and randomized checks of pc_gen_unit against a behavioural model
module tb_pc_gen_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        trap_valid_i = 1'b0;
    logic [31:0] trap_vec_i = '0;
    logic        halt_req_i = 1'b0;
    logic        resume_i = 1'b0;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        misaligned_o;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    pc_gen_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .redirect_valid_i(redirect_valid_i),
        .redirect_pc_i   (redirect_pc_i),
        .trap_valid_i    (trap_valid_i),
        .trap_vec_i      (trap_vec_i),
        .halt_req_i      (halt_req_i),
        .resume_i        (resume_i),
        .pc_o            (pc_o),
        .pc_valid_o      (pc_valid_o),
        .misaligned_o    (misaligned_o)
    );

    typedef struct packed {
        logic        trap;
        logic [31:0] addr;
    } pend_t;

    // Reference model: booting/halted flags plus a queue holding at most one parked request.
    bit          m_booting;
    bit          m_halted;
    logic [31:0] m_pc;
    bit          m_valid;
    bit          m_mis;
    pend_t       pend_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        pend_t e;
        if (rst) begin
            m_booting = 1; m_halted = 0; m_pc = 32'h0; m_valid = 0; m_mis = 0;
            pend_q.delete();
            return;
        end
        m_mis = 0;
        if (m_booting) begin
            m_booting = 0;
            m_valid   = 1;
            return;
        end
        if (m_halted || halt_req_i || stall_i) begin
            if (trap_valid_i) begin
                e.trap = 1; e.addr = trap_vec_i;
                pend_q.delete(); pend_q.push_back(e);
            end else if (redirect_valid_i && !(pend_q.size() > 0 && pend_q[0].trap)) begin
                e.trap = 0; e.addr = redirect_pc_i;
                pend_q.delete(); pend_q.push_back(e);
            end
            if (m_halted) begin
                if (resume_i && !halt_req_i) begin m_halted = 0; m_valid = 1; end
            end else if (halt_req_i) begin
                m_halted = 1; m_valid = 0;
            end
        end else begin
            logic [31:0] tgt;
            bit          take;
            take = 1;
            if (trap_valid_i)          tgt = trap_vec_i;
            else if (redirect_valid_i) tgt = redirect_pc_i;
            else if (pend_q.size() > 0) tgt = pend_q[0].addr;
            else begin take = 0; tgt = m_pc + 32'd4; end
            if (take) m_mis = (tgt % 4) != 0;
            m_pc = tgt;
            pend_q.delete();
        end
    endtask

    task automatic drive(input bit s, input bit rv, input logic [31:0] rpc,
                         input bit tv, input logic [31:0] tvec, input bit h, input bit r);
        stall_i = s; redirect_valid_i = rv; redirect_pc_i = rpc;
        trap_valid_i = tv; trap_vec_i = tvec; halt_req_i = h; resume_i = r;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("model_pc", pc_o, m_pc);
        check("model_valid", {31'b0, pc_valid_o}, {31'b0, m_valid});
        check("model_mis", {31'b0, misaligned_o}, {31'b0, m_mis});
    endtask

    task automatic expect_out(input string tag, input logic [31:0] pc, input bit v, input bit mis);
        check({tag, "_pc"}, pc_o, pc);
        check({tag, "_valid"}, {31'b0, pc_valid_o}, {31'b0, v});
        check({tag, "_mis"}, {31'b0, misaligned_o}, {31'b0, mis});
    endtask

    initial begin
        // Boot sequence
        rst = 1; drive(0, 0, 0, 0, 0, 0, 0);
        cycle(); expect_out("boot", 32'h0, 0, 0);
        rst = 0;
        cycle(); expect_out("run0", 32'h0, 1, 0);
        cycle(); expect_out("run4", 32'h4, 1, 0);
        cycle(); expect_out("run8", 32'h8, 1, 0);

        // Redirect
        drive(0, 1, 32'h100, 0, 0, 0, 0); cycle(); expect_out("redir", 32'h100, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0);       cycle(); expect_out("redir_inc", 32'h104, 1, 0);

        // Stall with stacked requests: trap wins, later redirect cannot displace it
        drive(1, 1, 32'h200, 0, 0, 0, 0); cycle(); expect_out("stall_a", 32'h104, 1, 0);
        drive(1, 0, 0, 1, 32'h80, 0, 0);  cycle(); expect_out("stall_b", 32'h104, 1, 0);
        drive(1, 1, 32'h300, 0, 0, 0, 0); cycle(); expect_out("stall_c", 32'h104, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0);       cycle(); expect_out("pend_trap", 32'h80, 1, 0);
        cycle(); expect_out("pend_inc", 32'h84, 1, 0);

        // Priority and misalignment
        drive(0, 1, 32'h40, 1, 32'h80, 0, 0); cycle(); expect_out("prio", 32'h80, 1, 0);
        drive(0, 1, 32'h102, 0, 0, 0, 0);     cycle(); expect_out("misal", 32'h102, 1, 1);
        drive(0, 0, 0, 0, 0, 0, 0);           cycle(); expect_out("misal_clr", 32'h106, 1, 0);

        // Halt with a redirect parked during HALT
        drive(0, 1, 32'h40, 0, 0, 0, 0);  cycle(); expect_out("to40", 32'h40, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 0);       cycle(); expect_out("halt", 32'h40, 0, 0);
        drive(0, 1, 32'h500, 0, 0, 0, 0); cycle(); expect_out("halt_req", 32'h40, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 1);       cycle(); expect_out("halt_both", 32'h40, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);       cycle(); expect_out("resume", 32'h40, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0);       cycle(); expect_out("resume_pend", 32'h500, 1, 0);

        // Wrap-around, then reset during a stall with a pending entry
        drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0); cycle(); expect_out("top", 32'hFFFF_FFFC, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0);             cycle(); expect_out("wrap", 32'h0, 1, 0);
        drive(1, 1, 32'h700, 0, 0, 0, 0);       cycle(); expect_out("pre_rst", 32'h0, 1, 0);
        rst = 1;                                cycle(); expect_out("rst_boot", 32'h0, 0, 0);
        rst = 0; drive(0, 0, 0, 0, 0, 0, 0);    cycle(); expect_out("rst_run", 32'h0, 1, 0);
        cycle(); expect_out("rst_empty", 32'h4, 1, 0);

        // Randomized phase against the model
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a, b;
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) != 0) b = b & 32'hFFFF_FFFC;
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, a,
                  $urandom_range(0, 11) == 0, b, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 2) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
